// File: rtl/zrb_uart_pkg.sv
// Shared types, parity-mode constants and elaboration helpers for the extended UART receiver.
package zrb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Unknown parity strings fall back to no parity.
    function automatic logic [1:0] par_decode(input string mode);
        if (mode == "EVEN") return PAR_EVEN;
        if (mode == "ODD")  return PAR_ODD;
        return PAR_NONE;
    endfunction

    function automatic int unsigned frame_len(input int unsigned data_bits,
                                              input logic        par_en,
                                              input int unsigned stop_bits);
        return 32'(1) + data_bits + (par_en ? 32'(1) : 32'(0)) + stop_bits;
    endfunction

    function automatic logic os_legal(input int unsigned os);
        return (os >= 32'(8)) && (os <= 32'(32)) && ((os & (os - 32'(1))) == 32'(0));
    endfunction

endpackage

// File: rtl/zrb_uart_rx_ext_if.sv
// Receiver-side signal bundle: serial line and oversample tick in, received word and status out.
interface zrb_uart_rx_ext_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 clk_en;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 busy;

    modport master (
        output clk_en, rx,
        input  data_out, valid, parity_err, frame_err, break_det, busy
    );

    modport slave (
        input  clk_en, rx,
        output data_out, valid, parity_err, frame_err, break_det, busy
    );
endinterface

// File: rtl/zrb_uart_bit_sampler.sv
// Oversample tick counter and bit-centre sampler; ZRB_UART_RX_MAJORITY_EN selects a 2-of-3 vote
// around the centre instead of a single sample.
module zrb_uart_bit_sampler #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clk_en,
    input  logic i_clear,
    input  logic i_rx,
    output logic o_strobe_c,
    output logic o_bit_c
);
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned MID   = OVERSAMPLE / 2;

    logic [CNT_W-1:0] r_cnt;

    // Free-running modulo-OVERSAMPLE phase, realigned to the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_clk_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef ZRB_UART_RX_MAJORITY_EN
    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (i_clk_en) begin
            if (r_cnt == CNT_W'(MID - 2)) r_s0 <= i_rx;
            if (r_cnt == CNT_W'(MID - 1)) r_s1 <= i_rx;
        end
    end

    assign o_strobe_c = i_clk_en && (r_cnt == CNT_W'(MID));
    assign o_bit_c    = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
`else
    assign o_strobe_c = i_clk_en && (r_cnt == CNT_W'(MID - 1));
    assign o_bit_c    = i_rx;
`endif

endmodule

// File: rtl/zrb_uart_rx_ext.sv
// Parametrised UART receiver with parity, framing and break detection and false-start rejection.
// Optional ZRB_UART_RX_MAJORITY_EN enables 2-of-3 majority sampling in zrb_uart_bit_sampler.
module zrb_uart_rx_ext
    import zrb_uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter string       PARITY     = "NO",
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    zrb_uart_rx_ext_if.slave rx_if
);
    localparam logic [1:0]  PMODE     = par_decode(PARITY);
    localparam logic        PAR_EN    = (PMODE != PAR_NONE);
    localparam int unsigned FRAME_LEN = frame_len(DATA_BITS, PAR_EN, STOP_BITS);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    if (!os_legal(OVERSAMPLE)) begin : g_bad_os
        $error("zrb_uart_rx_ext: OVERSAMPLE must be a power of two in 8..32");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("zrb_uart_rx_ext: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("zrb_uart_rx_ext: STOP_BITS must be 1 or 2");
    end

    state_t               r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_all_zero;
    logic                 r_edge_pend;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_sync_d;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_o;
    logic                 r_ferr_o;
    logic                 r_brk_o;
    logic                 r_busy;

    logic w_fall;
    logic w_start;
    logic w_strobe;
    logic w_bit;
    logic w_par_exp;
    logic w_frm_next;
    logic w_zero_next;

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_sync_d <= 1'b1;
        end else begin
            r_rx_meta   <= rx_if.rx;
            r_rx_sync   <= r_rx_meta;
            r_rx_sync_d <= r_rx_sync;
        end
    end

    assign w_fall      = r_rx_sync_d & ~r_rx_sync;
    assign w_start     = (r_state == ST_IDLE) && (w_fall || r_edge_pend);
    assign w_par_exp   = (^r_shift) ^ (PMODE == PAR_ODD);
    assign w_frm_next  = r_frm_err | ~w_bit;
    assign w_zero_next = r_all_zero & ~w_bit;

    zrb_uart_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .i_clk_en   (rx_if.clk_en),
        .i_clear    (w_start),
        .i_rx       (r_rx_sync),
        .o_strobe_c (w_strobe),
        .o_bit_c    (w_bit)
    );

    // Frame FSM; a start edge seen on the valid cycle is carried into IDLE by r_edge_pend.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_all_zero  <= 1'b0;
            r_edge_pend <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr_o    <= 1'b0;
            r_ferr_o    <= 1'b0;
            r_brk_o     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_edge_pend <= 1'b0;
            r_busy      <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_start) r_state <= ST_START;
                end
                ST_START: begin
                    if (w_strobe) begin
                        if (w_bit) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_DATA;
                            r_bit_cnt  <= CNT_W'(1);
                            r_par_err  <= 1'b0;
                            r_frm_err  <= 1'b0;
                            r_all_zero <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_strobe) begin
                        r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_all_zero <= w_zero_next;
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(DATA_BITS)) begin
                            r_state <= PAR_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_strobe) begin
                        r_par_err  <= (w_bit != w_par_exp);
                        r_all_zero <= w_zero_next;
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_strobe) begin
                        if (r_bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                            r_valid     <= 1'b1;
                            r_data      <= r_shift;
                            r_perr_o    <= r_par_err;
                            r_ferr_o    <= w_frm_next;
                            r_brk_o     <= w_zero_next;
                            r_edge_pend <= w_fall;
                            r_state     <= w_zero_next ? ST_BRK_WAIT : ST_IDLE;
                        end else begin
                            r_frm_err  <= w_frm_next;
                            r_all_zero <= w_zero_next;
                            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_BRK_WAIT: begin
                    if (r_rx_sync) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.data_out   = r_data;
    assign rx_if.valid      = r_valid;
    assign rx_if.parity_err = r_perr_o;
    assign rx_if.frame_err  = r_ferr_o;
    assign rx_if.break_det  = r_brk_o;
    assign rx_if.busy       = r_busy;

endmodule

// File: tb/tb_zrb_uart_rx_ext.sv
// Directed bench for zrb_uart_rx_ext: 8N1, 7E1 and 8N2 instances with clk_en tied high.
module tb_zrb_uart_rx_ext;
    localparam int unsigned OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rx_line;

    always #5 clk = ~clk;

    zrb_uart_rx_ext_if #(.DATA_BITS(8)) if0 ();
    zrb_uart_rx_ext_if #(.DATA_BITS(7)) if1 ();
    zrb_uart_rx_ext_if #(.DATA_BITS(8)) if2 ();

    assign if0.clk_en = 1'b1;
    assign if1.clk_en = 1'b1;
    assign if2.clk_en = 1'b1;
    assign if0.rx     = rx_line[0];
    assign if1.rx     = rx_line[1];
    assign if2.rx     = rx_line[2];

    zrb_uart_rx_ext #(.DATA_BITS(8), .PARITY("NO"), .STOP_BITS(1), .OVERSAMPLE(OS)) u_dut0 (
        .clk(clk), .reset(reset), .rx_if(if0));
    zrb_uart_rx_ext #(.DATA_BITS(7), .PARITY("EVEN"), .STOP_BITS(1), .OVERSAMPLE(OS)) u_dut1 (
        .clk(clk), .reset(reset), .rx_if(if1));
    zrb_uart_rx_ext #(.DATA_BITS(8), .PARITY("NO"), .STOP_BITS(2), .OVERSAMPLE(OS)) u_dut2 (
        .clk(clk), .reset(reset), .rx_if(if2));

    logic [2:0] mon_valid, mon_busy, mon_perr, mon_ferr, mon_brk;
    logic [8:0] mon_data [3];

    assign mon_valid   = {if2.valid, if1.valid, if0.valid};
    assign mon_busy    = {if2.busy, if1.busy, if0.busy};
    assign mon_perr    = {if2.parity_err, if1.parity_err, if0.parity_err};
    assign mon_ferr    = {if2.frame_err, if1.frame_err, if0.frame_err};
    assign mon_brk     = {if2.break_det, if1.break_det, if0.break_det};
    assign mon_data[0] = {1'b0, if0.data_out};
    assign mon_data[1] = {2'b00, if1.data_out};
    assign mon_data[2] = {1'b0, if2.data_out};

    int         vcnt [3];
    logic [8:0] vdata [3];
    logic [8:0] vdata_prev [3];
    logic       vperr [3];
    logic       vferr [3];
    logic       vbrk [3];
    int         vtime [3];
    int         vtime_prev [3];
    logic       busy_after [3];
    logic       pend [3];
    int         cyc;

    initial begin
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            vcnt[i] = 0; vdata[i] = '0; vdata_prev[i] = '0; vperr[i] = 0; vferr[i] = 0;
            vbrk[i] = 0; vtime[i] = 0; vtime_prev[i] = 0; busy_after[i] = 1; pend[i] = 0;
        end
    end

    // Capture every valid pulse and the busy level one clock later.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (pend[i]) begin
                busy_after[i] = mon_busy[i];
                pend[i] = 1'b0;
            end
            if (mon_valid[i]) begin
                vcnt[i]       = vcnt[i] + 1;
                vdata_prev[i] = vdata[i];
                vdata[i]      = mon_data[i];
                vperr[i]      = mon_perr[i];
                vferr[i]      = mon_ferr[i];
                vbrk[i]       = mon_brk[i];
                vtime_prev[i] = vtime[i];
                vtime[i]      = cyc;
                pend[i]       = 1'b1;
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [9:0] f8n1(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    function automatic logic [9:0] f7e1(input logic [6:0] d, input logic p);
        return {1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [10:0] f8n2(input logic [7:0] d, input logic s1, input logic s2);
        return {s2, s1, d, 1'b0};
    endfunction

    // Drive n line bits LSB first, one bit per OS clocks; optional one-clock glitch at a bit centre.
    task automatic send_bits(input int idx, input logic [31:0] bits, input int n, input int glitch);
        for (int i = 0; i < n; i++) begin
            rx_line[idx] = bits[i];
            if (i == glitch) begin
                repeat (OS / 2) @(negedge clk);
                rx_line[idx] = ~bits[i];
                @(negedge clk);
                rx_line[idx] = bits[i];
                repeat (OS / 2 - 1) @(negedge clk);
            end else begin
                repeat (OS) @(negedge clk);
            end
        end
        rx_line[idx] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;

    initial begin
        reset   = 1'b1;
        rx_line = 3'b111;
        idle(4);
        check("rst_data", 32'(if0.data_out), 32'h0);
        check("rst_valid", 32'(if0.valid), 32'h0);
        check("rst_perr", 32'(if0.parity_err), 32'h0);
        check("rst_ferr", 32'(if0.frame_err), 32'h0);
        check("rst_brk", 32'(if0.break_det), 32'h0);
        check("rst_busy", 32'(if0.busy), 32'h0);
        reset = 1'b0;
        idle(10);

        base = vcnt[0];
        send_bits(0, 32'(f8n1(8'hA5)), 10, -1);
        idle(20);
        check("a5_count", 32'(vcnt[0] - base), 32'd1);
        check("a5_data", 32'(vdata[0]), 32'hA5);
        check("a5_perr", 32'(vperr[0]), 32'h0);
        check("a5_ferr", 32'(vferr[0]), 32'h0);
        check("a5_brk", 32'(vbrk[0]), 32'h0);
        check("a5_busy_after", 32'(busy_after[0]), 32'h0);

        base = vcnt[0];
        rx_line[0] = 1'b0;
        idle(6);
        rx_line[0] = 1'b1;
        idle(40);
        check("fs_count", 32'(vcnt[0] - base), 32'd0);
        check("fs_busy", 32'(if0.busy), 32'h0);
        check("fs_data", 32'(if0.data_out), 32'hA5);

        base = vcnt[0];
        rx_line[0] = 1'b0;
        idle(30 * OS);
        check("brk_count", 32'(vcnt[0] - base), 32'd1);
        check("brk_det", 32'(vbrk[0]), 32'h1);
        check("brk_ferr", 32'(vferr[0]), 32'h1);
        check("brk_data", 32'(vdata[0]), 32'h0);
        check("brk_busy_wait", 32'(if0.busy), 32'h1);
        rx_line[0] = 1'b1;
        idle(60);
        check("brk_no_more", 32'(vcnt[0] - base), 32'd1);
        check("brk_idle", 32'(if0.busy), 32'h0);

        base = vcnt[0];
        send_bits(0, {12'h0, f8n1(8'hFE), f8n1(8'h01)}, 20, -1);
        idle(20);
        check("b2b_count", 32'(vcnt[0] - base), 32'd2);
        check("b2b_first", 32'(vdata_prev[0]), 32'h01);
        check("b2b_second", 32'(vdata[0]), 32'hFE);
        check("b2b_spacing", 32'(vtime[0] - vtime_prev[0]), 32'd160);

        base = vcnt[0];
        send_bits(0, 32'(f8n1(8'h55)), 4, -1);
        check("mid_busy", 32'(if0.busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_data", 32'(if0.data_out), 32'h0);
        check("mid_rst_busy", 32'(if0.busy), 32'h0);
        check("mid_rst_flags", {29'h0, if0.parity_err, if0.frame_err, if0.break_det}, 32'h0);
        reset = 1'b0;
        idle(40);
        check("mid_no_valid", 32'(vcnt[0] - base), 32'd0);
        send_bits(0, 32'(f8n1(8'h0F)), 10, -1);
        idle(20);
        check("0f_count", 32'(vcnt[0] - base), 32'd1);
        check("0f_data", 32'(vdata[0]), 32'h0F);
        check("0f_ferr", 32'(vferr[0]), 32'h0);

        // 0x35 has four ones, so even parity expects 0.
        base = vcnt[1];
        send_bits(1, 32'(f7e1(7'h35, 1'b1)), 10, -1);
        idle(20);
        check("7e1_bad_count", 32'(vcnt[1] - base), 32'd1);
        check("7e1_bad_perr", 32'(vperr[1]), 32'h1);
        check("7e1_bad_data", 32'(vdata[1]), 32'h35);
        send_bits(1, 32'(f7e1(7'h35, 1'b0)), 10, -1);
        idle(20);
        check("7e1_ok_count", 32'(vcnt[1] - base), 32'd2);
        check("7e1_ok_perr", 32'(vperr[1]), 32'h0);
        check("7e1_ok_data", 32'(vdata[1]), 32'h35);

        base = vcnt[2];
        send_bits(2, 32'(f8n2(8'h81, 1'b1, 1'b0)), 11, -1);
        idle(20);
        check("8n2_bad_count", 32'(vcnt[2] - base), 32'd1);
        check("8n2_bad_ferr", 32'(vferr[2]), 32'h1);
        check("8n2_bad_data", 32'(vdata[2]), 32'h81);
        check("8n2_bad_brk", 32'(vbrk[2]), 32'h0);
        send_bits(2, 32'(f8n2(8'h3C, 1'b1, 1'b1)), 11, -1);
        idle(20);
        check("8n2_ok_count", 32'(vcnt[2] - base), 32'd2);
        check("8n2_ok_ferr", 32'(vferr[2]), 32'h0);
        check("8n2_ok_data", 32'(vdata[2]), 32'h3C);

`ifdef ZRB_UART_RX_MAJORITY_EN
        base = vcnt[0];
        send_bits(0, 32'(f8n1(8'h42)), 10, 4);
        idle(20);
        check("maj_count", 32'(vcnt[0] - base), 32'd1);
        check("maj_data", 32'(vdata[0]), 32'h42);
        check("maj_ferr", 32'(vferr[0]), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
